// File: rtl/axi_master_rd_data_drain_if.sv
// Bundle of the command, FIFO read-port and output-stream signals around the
// read-data drain.
//   master : the drain's view. It accepts commands, pops the FIFO and drives the
//            output stream.
//   slave  : the environment's view. It issues commands, provides the FIFO and
//            sinks the stream.
// Signals:
//   cmd_valid/cmd_ready/cmd_len/cmd_id     burst command handshake
//   fifo_rd_en/fifo_rd_empty/fifo_rd_data  non-FWFT FIFO read port (1-cycle latency)
//   m_valid/m_ready/m_data/m_last/m_id     output beat stream
interface axi_master_rd_data_drain_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic [7:0]        cmd_len;
  logic [ID_W-1:0]   cmd_id;
  logic              fifo_rd_en;
  logic              fifo_rd_empty;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic [ID_W-1:0]   m_id;

  modport master (
    input  cmd_valid, cmd_len, cmd_id, fifo_rd_empty, fifo_rd_data, m_ready,
    output cmd_ready, fifo_rd_en, m_valid, m_data, m_last, m_id
  );

  modport slave (
    output cmd_valid, cmd_len, cmd_id, fifo_rd_empty, fifo_rd_data, m_ready,
    input  cmd_ready, fifo_rd_en, m_valid, m_data, m_last, m_id
  );
endinterface

// File: rtl/axi_master_rd_data_drain.sv
// Read-data drain for the master-side async read FIFO. It runs in the FIFO's
// read-clock domain.
//
// The block accepts a burst command (beats = cmd_len + 1, ID) and pops exactly
// that many words from the FIFO's standard (1-cycle latency) read port. A small
// prefetch buffer turns those words into a valid/ready stream that carries a
// generated last flag and the burst ID.
//
// Ports:
//   clk   read-side clock
//   rstn  asynchronous active-low reset
//   bus   command, FIFO read port and output stream (master modport)
//   busy  high while a burst is active
module axi_master_rd_data_drain #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned BUF_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  axi_master_rd_data_drain_if.master bus,
  output logic                       busy
);
  localparam int unsigned PtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);
  localparam logic [CntW:0] DepthC = (CntW + 1)'(BUF_DEPTH);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e            state_q;
  logic [ID_W-1:0]   id_q;
  logic [8:0]        rem_issue_q;
  logic [8:0]        rem_out_q;
  logic              inflight_q;
  logic [CntW-1:0]   buf_cnt_q;
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [DATA_W-1:0] mem_q [BUF_DEPTH];

  logic            rd_en;
  logic            push;
  logic            pop;
  logic            done;
  logic            m_valid;
  logic [CntW:0]   occupancy;

  always_comb begin
    // Count words already buffered plus the one still in flight from the FIFO,
    // so a read is issued only when its data is certain to have a slot.
    occupancy = {1'b0, buf_cnt_q} + {{CntW{1'b0}}, inflight_q};
    rd_en     = (state_q == StBurst) && !bus.fifo_rd_empty && (rem_issue_q != 9'd0) &&
                (occupancy < DepthC);
    m_valid   = (buf_cnt_q != '0);
    push      = inflight_q;
    pop       = m_valid && bus.m_ready;
    done      = pop && (rem_out_q == 9'd1);
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.cmd_ready  = (state_q == StIdle);
  assign busy           = (state_q == StBurst);
  assign bus.m_valid    = m_valid;
  assign bus.m_data     = mem_q[rd_ptr_q];
  assign bus.m_last     = m_valid && (rem_out_q == 9'd1);
  assign bus.m_id       = id_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      id_q        <= '0;
      rem_issue_q <= '0;
      rem_out_q   <= '0;
      inflight_q  <= 1'b0;
      buf_cnt_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.cmd_valid) begin
            id_q        <= bus.cmd_id;
            rem_issue_q <= {1'b0, bus.cmd_len} + 9'd1;
            rem_out_q   <= {1'b0, bus.cmd_len} + 9'd1;
            state_q     <= StBurst;
          end
        end
        StBurst: begin
          if (rd_en) rem_issue_q <= rem_issue_q - 9'd1;
          if (pop)   rem_out_q   <= rem_out_q - 9'd1;
          if (done)  state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      inflight_q <= rd_en;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   buf_cnt_q <= buf_cnt_q + CntW'(1);
        2'b01:   buf_cnt_q <= buf_cnt_q - CntW'(1);
        default: buf_cnt_q <= buf_cnt_q;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by buf_cnt_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.fifo_rd_data;
  end

`ifndef SYNTHESIS
  buf_cnt_le_depth: assert property (@(posedge clk) disable iff (!rstn)
    buf_cnt_q <= CntW'(BUF_DEPTH));
`endif
endmodule
